// File: rtl/bird_pkg.sv
// Shared definitions for the bird game blocks (bird physics, pipes, collision).
package bird_pkg;

  // Game state as seen by the physics, renderer and collision logic.
  typedef enum logic [1:0] {
    READY  = 2'd0,
    FLYING = 2'd1,
    DEAD   = 2'd2
  } state_t;

  // Screen and sprite geometry.
  localparam int SCREEN_H_DEF  = 480;
  localparam int BIRD_SIZE_DEF = 15;

  // Physics defaults, in pixels and pixels per tick.
  localparam int TICK_DIV_DEF  = 4166667;
  localparam int GRAVITY_DEF   = 1;
  localparam int FLAP_VEL_DEF  = 6;
  localparam int MAX_FALL_DEF  = 8;

endpackage

// File: rtl/tick_divider.sv
// Physics tick generator: counts enabled clk cycles and pulses tick on the last
// count of each TICK_DIV-cycle period. Disabling holds the count; clr zeroes it.
module tick_divider #(
  parameter int TICK_DIV = 4166667
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // tick is combinational so the consumer acts on the same edge the count wraps
  assign tick = en && (count == LAST);

  // Period counter: clear wins over enable, wraps to zero on the tick cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/bird_physics.sv
// Bird vertical physics: signed velocity with gravity, terminal fall speed and a
// flap impulse, advanced once per physics tick, plus the READY/FLYING/DEAD
// game state. Produces the bird bounding box and ceiling/floor event pulses.
module bird_physics
  import bird_pkg::*;
#(
  parameter int N         = 11,
  parameter int V_W       = 8,
  parameter int BIRD_SIZE = BIRD_SIZE_DEF,
  parameter int START_X   = 160,
  parameter int START_Y   = 240,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int GRAVITY   = GRAVITY_DEF,
  parameter int FLAP_VEL  = FLAP_VEL_DEF,
  parameter int MAX_FALL  = MAX_FALL_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flap,
  input  logic                  pause,
  input  logic                  restart,
  output logic signed [N-1:0]   x0,
  output logic signed [N-1:0]   x1,
  output logic signed [N-1:0]   y0,
  output logic signed [N-1:0]   y1,
  output logic signed [V_W-1:0] vel,
  output logic                  alive,
  output logic                  hit_top,
  output logic                  hit_bottom,
  output state_t                dbg_state
);

  localparam logic signed [N-1:0]   Y1_START  = N'(START_Y - BIRD_SIZE / 2);
  localparam logic signed [N-1:0]   Y0_START  = N'(START_Y - BIRD_SIZE / 2 + BIRD_SIZE - 1);
  localparam logic signed [N-1:0]   Y1_FLOOR  = N'(SCREEN_H - BIRD_SIZE);
  localparam logic signed [N-1:0]   Y0_FLOOR  = N'(SCREEN_H - 1);
  localparam logic signed [N-1:0]   BOX_SPAN  = N'(BIRD_SIZE - 1);
  localparam logic signed [N+1:0]   BOT_LIMIT = (N+2)'(SCREEN_H - 1);
  localparam logic signed [N+1:0]   BOX_EXT   = (N+2)'(BIRD_SIZE - 1);
  localparam logic signed [V_W:0]   FALL_LIM  = (V_W+1)'(MAX_FALL);
  localparam logic signed [V_W:0]   GRAV_INC  = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W-1:0] FLAP_V    = V_W'(-FLAP_VEL);

  state_t state;
  logic   flap_q;
  logic   pending;
  logic   flap_edge;
  logic   tick;

  logic signed [V_W:0]   vel_inc;
  logic signed [V_W-1:0] nv;
  logic signed [N:0]     ny1;
  logic signed [N+1:0]   ny_bot;

  // Horizontal position never changes
  assign x0 = N'(START_X);
  assign x1 = N'(START_X + BIRD_SIZE - 1);

  assign dbg_state = state;
  assign flap_edge = flap & ~flap_q;

  // Physics only advances while flying and not paused; any other state parks
  // the divider at zero so a fresh launch always waits a full period
  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      ((state == FLYING) && !pause),
    .clr     (restart || (state != FLYING)),
    .tick    (tick)
  );

  // Next velocity and position candidates, widened so overflow past the
  // ceiling or floor is visible before clamping
  always_comb begin
    vel_inc = (V_W+1)'(vel) + GRAV_INC;
    if (pending || flap_edge) begin
      nv = FLAP_V;
    end else if (vel_inc > FALL_LIM) begin
      nv = V_W'(MAX_FALL);
    end else begin
      nv = vel_inc[V_W-1:0];
    end
    ny1    = (N+1)'(y1) + (N+1)'(nv);
    ny_bot = (N+2)'(ny1) + BOX_EXT;
  end

  // Game state machine with position, velocity and event outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= READY;
      flap_q     <= 1'b0;
      pending    <= 1'b0;
      y1         <= Y1_START;
      y0         <= Y0_START;
      vel        <= '0;
      alive      <= 1'b1;
      hit_top    <= 1'b0;
      hit_bottom <= 1'b0;
    end else begin
      // flap_q samples even during restart so a held flap cannot re-launch
      flap_q     <= flap;
      hit_top    <= 1'b0;
      hit_bottom <= 1'b0;
      if (restart) begin
        state   <= READY;
        pending <= 1'b0;
        y1      <= Y1_START;
        y0      <= Y0_START;
        vel     <= '0;
        alive   <= 1'b1;
      end else begin
        case (state)
          READY: begin
            if (flap_edge) begin
              state   <= FLYING;
              pending <= 1'b1;
            end
          end
          FLYING: begin
            if (tick) begin
              pending <= 1'b0;
              if (ny1[N]) begin
                y1      <= '0;
                y0      <= BOX_SPAN;
                vel     <= '0;
                hit_top <= 1'b1;
              end else if (ny_bot >= BOT_LIMIT) begin
                y1         <= Y1_FLOOR;
                y0         <= Y0_FLOOR;
                vel        <= '0;
                state      <= DEAD;
                alive      <= 1'b0;
                hit_bottom <= 1'b1;
              end else begin
                y1  <= ny1[N-1:0];
                y0  <= ny1[N-1:0] + BOX_SPAN;
                vel <= nv;
              end
            end else if (flap_edge) begin
              pending <= 1'b1;
            end
          end
          DEAD: begin
            // frozen until restart or reset
          end
          default: begin
            state <= READY;
          end
        endcase
      end
    end
  end

endmodule
